// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared USR opcode constants and frame-length helper
package usr_pkg;

  localparam logic [1:0] USR_OP_HOLD        = 2'd0;
  localparam logic [1:0] USR_OP_SHIFT_LEFT  = 2'd1;
  localparam logic [1:0] USR_OP_SHIFT_RIGHT = 2'd2;
  localparam logic [1:0] USR_OP_LOAD        = 2'd3;

  // Zero and anything above 8 both mean a full 8-bit frame.
  function automatic logic [3:0] norm_bit_count(input logic [3:0] raw);
    return (raw == 4'd0 || raw > 4'd8) ? 4'd8 : raw;
  endfunction

endpackage

// File: rtl/usr_bit_timer.sv
// rtl/usr_bit_timer.sv - parameterised bit-period divider with clear and single-cycle tick
module usr_bit_timer #(
  parameter int unsigned PERIOD = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count 0..PERIOD-1 and wrap; clear forces the next count back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/usr_frame_sequencer.sv
// rtl/usr_frame_sequencer.sv - sequences USR load/shift ops for one 1..8 bit frame
module usr_frame_sequencer
  import usr_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = 4,
  parameter int unsigned DIV_W      = 8
) (
  input  logic       Clk_In,
  input  logic       Reset_In,
  input  logic       Start_In,
  input  logic       Abort_In,
  input  logic       Mode_In,
  input  logic       Direction_In,
  input  logic [3:0] Bit_Count_In,
  output logic       USR_Enable_Out,
  output logic [1:0] USR_Operation_Select_Out,
  output logic       Busy_Out,
  output logic       Done_Out,
  output logic       Aborted_Out
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

  state_t     state_q, state_d;
  logic       dir_q, dir_d;
  logic [3:0] n_q, n_d;
  logic [3:0] bits_q, bits_d;
  logic       en_q, en_d;
  logic [1:0] op_q, op_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;

  logic       start_ok;
  logic       timer_clear;
  logic       tick;
  logic [1:0] shift_op;

  assign start_ok = Start_In && !Abort_In;
  assign shift_op = dir_q ? USR_OP_SHIFT_RIGHT : USR_OP_SHIFT_LEFT;

  // Outputs are registered, so the divider runs one cycle ahead: its tick in
  // cycle c puts the shift opcode on the bus in cycle c+1. It starts counting
  // in the accepting IDLE cycle for receive and in the LOAD cycle for
  // transmit, and is held at zero whenever the next state is IDLE.
  assign timer_clear = (state_q == ST_IDLE && !(start_ok && Mode_In)) ||
                       (state_q == ST_DONE) ||
                       (Abort_In && (state_q == ST_LOAD || state_q == ST_SHIFT));

  usr_bit_timer #(
    .PERIOD(BIT_PERIOD),
    .CNT_W (DIV_W)
  ) u_bit_timer (
    .clk  (Clk_In),
    .rst  (Reset_In),
    .clear(timer_clear),
    .tick (tick)
  );

  // Next-state and next-output computation for the frame FSM.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    n_d       = n_q;
    bits_d    = bits_q;
    en_d      = 1'b1;
    op_d      = USR_OP_HOLD;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bits_d = 4'd0;
        if (start_ok) begin
          dir_d = Direction_In;
          n_d   = norm_bit_count(Bit_Count_In);
          // Mode only picks the first state, so it is not kept.
          if (!Mode_In) begin
            state_d = ST_LOAD;
            op_d    = USR_OP_LOAD;
          end else begin
            state_d = ST_SHIFT;
            if (tick) begin
              op_d   = Direction_In ? USR_OP_SHIFT_RIGHT : USR_OP_SHIFT_LEFT;
              bits_d = 4'd1;
            end
          end
        end
      end
      ST_LOAD: begin
        if (Abort_In) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          bits_d    = 4'd0;
        end else begin
          state_d = ST_SHIFT;
          if (tick) begin
            op_d   = shift_op;
            bits_d = bits_q + 4'd1;
          end
        end
      end
      ST_SHIFT: begin
        if (Abort_In) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          bits_d    = 4'd0;
        end else if (bits_q == n_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (tick) begin
          op_d   = shift_op;
          bits_d = bits_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        bits_d  = 4'd0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q   <= ST_IDLE;
      dir_q     <= 1'b0;
      n_q       <= 4'd0;
      bits_q    <= 4'd0;
      en_q      <= 1'b0;
      op_q      <= USR_OP_HOLD;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      n_q       <= n_d;
      bits_q    <= bits_d;
      en_q      <= en_d;
      op_q      <= op_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign USR_Enable_Out           = en_q;
  assign USR_Operation_Select_Out = op_q;
  assign Busy_Out                 = busy_q;
  assign Done_Out                 = done_q;
  assign Aborted_Out              = aborted_q;

endmodule

// File: tb/tb_usr_frame_sequencer.sv
// tb/tb_usr_frame_sequencer.sv - scoreboard bench for usr_frame_sequencer at bit periods 4, 2 and 1
module tb_usr_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, mode, dir;
  logic [3:0] bc;

  logic       en4, busy4, done4, ab4;
  logic [1:0] op4;
  logic       en2, busy2, done2, ab2;
  logic [1:0] op2;
  logic       en1, busy1, done1, ab1;
  logic [1:0] op1;

  usr_frame_sequencer #(.BIT_PERIOD(4), .DIV_W(8)) u_dut_p4 (
    .Clk_In(clk), .Reset_In(rst), .Start_In(start), .Abort_In(abort),
    .Mode_In(mode), .Direction_In(dir), .Bit_Count_In(bc),
    .USR_Enable_Out(en4), .USR_Operation_Select_Out(op4),
    .Busy_Out(busy4), .Done_Out(done4), .Aborted_Out(ab4)
  );

  usr_frame_sequencer #(.BIT_PERIOD(2), .DIV_W(8)) u_dut_p2 (
    .Clk_In(clk), .Reset_In(rst), .Start_In(start), .Abort_In(abort),
    .Mode_In(mode), .Direction_In(dir), .Bit_Count_In(bc),
    .USR_Enable_Out(en2), .USR_Operation_Select_Out(op2),
    .Busy_Out(busy2), .Done_Out(done2), .Aborted_Out(ab2)
  );

  usr_frame_sequencer #(.BIT_PERIOD(1), .DIV_W(8)) u_dut_p1 (
    .Clk_In(clk), .Reset_In(rst), .Start_In(start), .Abort_In(abort),
    .Mode_In(mode), .Direction_In(dir), .Bit_Count_In(bc),
    .USR_Enable_Out(en1), .USR_Operation_Select_Out(op1),
    .Busy_Out(busy1), .Done_Out(done1), .Aborted_Out(ab1)
  );

  typedef struct {
    int          scn;
    int          cyc;
    logic [17:0] e;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  // Behavioural USR fed by the period-2 instance, latching on the falling edge.
  logic [7:0] usr_q;
  logic [2:0] sin_idx;
  logic       usr_clear, usr_chk;
  logic       rx_pat [0:7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  always @(negedge clk) begin
    if (usr_clear) begin
      usr_q   <= 8'h00;
      sin_idx <= 3'd0;
    end else if (en2 && op2 == 2'd2) begin
      usr_q   <= {rx_pat[sin_idx], usr_q[7:1]};
      sin_idx <= sin_idx + 3'd1;
    end
  end

  // Expected {en, op, busy, done, aborted} for cycle c, from the frame timeline.
  function automatic logic [5:0] model(int p, int c, logic m, logic d, int nraw,
                                       bit nostart, int ac, int rc);
    int         n, off, dc;
    logic [1:0] op;
    n   = (nraw == 0 || nraw > 8) ? 8 : nraw;
    off = m ? 0 : 1;
    dc  = off + n * p + 1;
    if (rc >= 0 && c == rc + 1) return 6'b000000;
    if (rc >= 0 && c > rc + 1) return 6'b100000;
    if (nostart || c <= 0) return 6'b100000;
    if (ac >= 1 && ac <= dc - 1) begin
      if (c == ac + 1) return 6'b100001;
      if (c > ac + 1) return 6'b100000;
    end
    if (c > dc) return 6'b100000;
    if (c == dc) return 6'b100110;
    op = 2'd0;
    if (!m && c == 1) op = 2'd3;
    else if (c > off && ((c - off) % p) == 0) op = d ? 2'd2 : 2'd1;
    return {1'b1, op, 1'b1, 2'b00};
  endfunction

  task automatic push_exp(int id, int c, logic [17:0] e);
    exp_t t;
    t.scn = id;
    t.cyc = c;
    t.e   = e;
    exp_q.push_back(t);
  endtask

  // One frame scenario: Start in cycle 0, optional abort/reset/restart cycles.
  task automatic run_scn(int id, logic m, logic d, int nraw, int ac, int rc, int sc, bit both);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      start = (c == 0) || (c == sc);
      abort = (c == ac) || (both && c == 0);
      rst   = (c == rc);
      if (c == sc) begin
        mode = ~m;
        dir  = ~d;
        bc   = 4'd2;
      end else begin
        mode = m;
        dir  = d;
        bc   = 4'(nraw);
      end
      push_exp(id, c, {model(4, c, m, d, nraw, both, ac, rc),
                       model(2, c, m, d, nraw, both, ac, rc),
                       model(1, c, m, d, nraw, both, ac, rc)});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  // Monitor: pop one expectation per cycle and compare all three instances.
  always @(negedge clk) begin
    logic [17:0] act;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      act = {en4, op4, busy4, done4, ab4, en2, op2, busy2, done2, ab2,
             en1, op1, busy1, done1, ab1};
      for (int i = 0; i < 3; i++) begin
        total++;
        if (act[17-6*i -: 6] !== cur.e[17-6*i -: 6]) begin
          bad++;
          $display("FAIL outputs_p%0d scn=%0d cyc=%0d got{en,op,busy,done,ab}=%b want=%b",
                   (i == 0) ? 4 : ((i == 1) ? 2 : 1), cur.scn, cur.cyc,
                   act[17-6*i -: 6], cur.e[17-6*i -: 6]);
        end
      end
    end
    if (usr_chk) begin
      total++;
      if (usr_q !== 8'hA0) begin
        bad++;
        $display("FAIL usr_rx_contents got=%b want=%b", usr_q, 8'hA0);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    mode      = 1'b0;
    dir       = 1'b0;
    bc        = 4'd0;
    usr_clear = 1'b1;
    usr_chk   = 1'b0;

    @(posedge clk);
    #1;
    push_exp(0, 0, 18'b0);
    @(posedge clk);
    #1;
    push_exp(0, 1, 18'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_exp(0, 2, {3{6'b100000}});

    //       id m     d     n   abort rst sc  both
    run_scn(1,  1'b0, 1'b0, 8,  -1,   -1, -1, 1'b0);
    usr_clear = 1'b0;
    run_scn(2,  1'b1, 1'b1, 3,  -1,   -1, -1, 1'b0);
    usr_chk = 1'b1;
    @(posedge clk);
    #1;
    usr_chk   = 1'b0;
    usr_clear = 1'b1;
    run_scn(3,  1'b0, 1'b1, 0,  -1,   -1, -1, 1'b0);
    run_scn(4,  1'b1, 1'b0, 12, -1,   -1, -1, 1'b0);
    run_scn(5,  1'b0, 1'b0, 1,  -1,   -1, -1, 1'b0);
    run_scn(6,  1'b0, 1'b0, 8,  6,    -1, -1, 1'b0);
    run_scn(7,  1'b0, 1'b0, 8,  -1,   -1, -1, 1'b1);
    run_scn(8,  1'b0, 1'b0, 8,  -1,   -1, 10, 1'b0);
    run_scn(9,  1'b0, 1'b0, 8,  -1,   12, -1, 1'b0);
    run_scn(10, 1'b1, 1'b1, 2,  8,    -1, -1, 1'b0);
    run_scn(11, 1'b0, 1'b0, 1,  3,    -1, -1, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
